// File: rtl/reg_bank_gen.sv
// reg_bank_gen: parametrised CPU register bank.
// - Two combinational read ports with same-cycle write bypass.
// - One write port, frozen while the core is halted.
// - Optional hardwired-zero register 0.
// - Handshaked debug dump sequencer. While halted, it streams the low DUMP_W bits
//   of every register to the display/debug logic.
module reg_bank_gen #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int ZERO_REG = 1,
  parameter int DUMP_W   = 8
) (
  input  logic              clk,
  input  logic              resetN,
  input  logic [ADDR_W-1:0] readAddress1,
  input  logic [ADDR_W-1:0] readAddress2,
  output logic [DATA_W-1:0] data1,
  output logic [DATA_W-1:0] data2,
  input  logic [ADDR_W-1:0] writeAddress,
  input  logic [DATA_W-1:0] dataWrite,
  input  logic              writeMark,
  input  logic              hlt,
  input  logic              dumpReady,
  output logic              dumpValid,
  output logic [ADDR_W-1:0] dumpAddress,
  output logic [DUMP_W-1:0] dumpValue,
  output logic              dumpDone
);

  localparam int DEPTH = 1 << ADDR_W;

  localparam logic [ADDR_W-1:0] ADDR_ZERO = {ADDR_W{1'b0}};
  localparam logic [ADDR_W-1:0] ADDR_LAST = {ADDR_W{1'b1}};
  localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1);
  localparam logic [DATA_W-1:0] DATA_ZERO = {DATA_W{1'b0}};
  localparam logic [DUMP_W-1:0] DUMP_ZERO = {DUMP_W{1'b0}};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } dump_state_t;

  // Register storage and dump sequencer state
  logic [DATA_W-1:0] rb_r [DEPTH];
  dump_state_t       state_r;
  logic [ADDR_W-1:0] ptr_r;
  logic              hlt_prev_r;
  logic              dump_valid_r;
  logic [ADDR_W-1:0] dump_addr_r;
  logic [DUMP_W-1:0] dump_value_r;
  logic              dump_done_r;

  // Combinational helpers
  logic              wr_live_s;
  logic              wr_en_s;
  logic              hlt_rise_s;
  logic [ADDR_W-1:0] ptr_next_s;

  // True when this address is the hardwired-zero register
  function automatic logic is_zero_reg(input logic [ADDR_W-1:0] addr);
    return (ZERO_REG != 0) && (addr == ADDR_ZERO);
  endfunction

  // Low DUMP_W bits of a register word, as presented on the dump port
  function automatic logic [DUMP_W-1:0] dump_slice(input logic [DATA_W-1:0] word);
    return word[DUMP_W-1:0];
  endfunction

  // Read one port, in priority order: hardwired zero, then write bypass, then storage
  function automatic logic [DATA_W-1:0] read_port(
    input logic [ADDR_W-1:0] raddr,
    input logic              live,
    input logic [ADDR_W-1:0] waddr,
    input logic [DATA_W-1:0] wdata,
    input logic [DATA_W-1:0] stored
  );
    logic [DATA_W-1:0] res;
    if (is_zero_reg(raddr)) begin
      res = DATA_ZERO;
    end else if (live && (waddr == raddr)) begin
      res = wdata;
    end else begin
      res = stored;
    end
    return res;
  endfunction

  // Qualify writes.
  // A halted core never writes, so the dumped image stays frozen.
  always_comb begin
    wr_live_s  = 1'b0;
    wr_en_s    = 1'b0;
    hlt_rise_s = 1'b0;
    ptr_next_s = ptr_r;
    if (writeMark && !hlt) begin
      wr_live_s = 1'b1;
    end else begin
      wr_live_s = 1'b0;
    end
    if (wr_live_s && !is_zero_reg(writeAddress)) begin
      wr_en_s = 1'b1;
    end else begin
      wr_en_s = 1'b0;
    end
    if (hlt && !hlt_prev_r) begin
      hlt_rise_s = 1'b1;
    end else begin
      hlt_rise_s = 1'b0;
    end
    if (ptr_r != ADDR_LAST) begin
      ptr_next_s = ptr_r + ADDR_ONE;
    end else begin
      ptr_next_s = ptr_r;
    end
  end

  // Both read ports, each with its own independent bypass
  always_comb begin
    data1 = DATA_ZERO;
    data2 = DATA_ZERO;
    data1 = read_port(readAddress1, wr_live_s, writeAddress, dataWrite, rb_r[readAddress1]);
    data2 = read_port(readAddress2, wr_live_s, writeAddress, dataWrite, rb_r[readAddress2]);
  end

  // Register file write port
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      for (int i = 0; i < DEPTH; i++) begin
        rb_r[i] <= DATA_ZERO;
      end
    end else begin
      if (wr_en_s) begin
        rb_r[writeAddress] <= dataWrite;
      end
    end
  end

  // Dump sequencer.
  // Outputs are registered and loaded with the beat that the next state will present.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_r      <= IDLE;
      ptr_r        <= ADDR_ZERO;
      hlt_prev_r   <= 1'b0;
      dump_valid_r <= 1'b0;
      dump_addr_r  <= ADDR_ZERO;
      dump_value_r <= DUMP_ZERO;
      dump_done_r  <= 1'b0;
    end else begin
      hlt_prev_r <= hlt;
      case (state_r)
        IDLE: begin
          if (hlt_rise_s) begin
            state_r      <= SCAN;
            ptr_r        <= ADDR_ZERO;
            dump_valid_r <= 1'b1;
            dump_addr_r  <= ADDR_ZERO;
            dump_value_r <= is_zero_reg(ADDR_ZERO) ? DUMP_ZERO : dump_slice(rb_r[0]);
            dump_done_r  <= 1'b0;
          end else begin
            state_r      <= IDLE;
            ptr_r        <= ADDR_ZERO;
            dump_valid_r <= 1'b0;
            dump_addr_r  <= ADDR_ZERO;
            dump_value_r <= DUMP_ZERO;
            dump_done_r  <= 1'b0;
          end
        end
        SCAN: begin
          if (!hlt) begin
            // Abort wins over a beat accepted in the same cycle
            state_r      <= IDLE;
            ptr_r        <= ADDR_ZERO;
            dump_valid_r <= 1'b0;
            dump_addr_r  <= ADDR_ZERO;
            dump_value_r <= DUMP_ZERO;
            dump_done_r  <= 1'b0;
          end else if (dumpReady && (ptr_r == ADDR_LAST)) begin
            state_r      <= DONE;
            ptr_r        <= ADDR_ZERO;
            dump_valid_r <= 1'b0;
            dump_addr_r  <= ADDR_ZERO;
            dump_value_r <= DUMP_ZERO;
            dump_done_r  <= 1'b1;
          end else if (dumpReady) begin
            state_r      <= SCAN;
            ptr_r        <= ptr_next_s;
            dump_valid_r <= 1'b1;
            dump_addr_r  <= ptr_next_s;
            dump_value_r <= dump_slice(rb_r[ptr_next_s]);
            dump_done_r  <= 1'b0;
          end else begin
            // Back-pressure: hold the current beat stable
            state_r      <= SCAN;
            ptr_r        <= ptr_r;
            dump_valid_r <= 1'b1;
            dump_addr_r  <= dump_addr_r;
            dump_value_r <= dump_value_r;
            dump_done_r  <= 1'b0;
          end
        end
        DONE: begin
          if (!hlt) begin
            state_r     <= IDLE;
            dump_done_r <= 1'b0;
          end else begin
            state_r     <= DONE;
            dump_done_r <= 1'b1;
          end
          ptr_r        <= ADDR_ZERO;
          dump_valid_r <= 1'b0;
          dump_addr_r  <= ADDR_ZERO;
          dump_value_r <= DUMP_ZERO;
        end
        default: begin
          state_r      <= IDLE;
          ptr_r        <= ADDR_ZERO;
          dump_valid_r <= 1'b0;
          dump_addr_r  <= ADDR_ZERO;
          dump_value_r <= DUMP_ZERO;
          dump_done_r  <= 1'b0;
        end
      endcase
    end
  end

  assign dumpValid   = dump_valid_r;
  assign dumpAddress = dump_addr_r;
  assign dumpValue   = dump_value_r;
  assign dumpDone    = dump_done_r;

endmodule
